// File: rtl/irq_pend8_pkg.sv
// ----------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the irq_pend8 interrupt pending/arbitration stage:
// vector widths, the grant FSM state type and a one-hot decode helper.
// ----------------------------------------------------------------------------
package irq_pkg;

    localparam int N_IRQ    = 8;
    localparam int IRQ_ID_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_e;

    // One-hot vector with only bit 'id' set; used to clear the accepted line.
    function automatic logic [N_IRQ-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
        logic [N_IRQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_pend8_if.sv
// ----------------------------------------------------------------------------
// irq_pend8_if
// Bundles the request/mask inputs, the id valid/ready handshake and the raw
// pending vector of irq_pend8.
//   req       : asynchronous request lines, bit 7 highest priority
//   mask      : per-line enable, 1 = enabled
//   irq_ready : downstream accepts the presented id
//   irq_valid : an id is being presented
//   irq_id    : index of the granted request
//   pending   : raw pending register, before masking
// Modports: slave = the pending stage, master = the side driving requests and
// consuming grants.
// ----------------------------------------------------------------------------
interface irq_pend8_if;
    import irq_pkg::*;

    logic [N_IRQ-1:0]    req;
    logic [N_IRQ-1:0]    mask;
    logic                irq_ready;
    logic                irq_valid;
    logic [IRQ_ID_W-1:0] irq_id;
    logic [N_IRQ-1:0]    pending;

    modport master (
        output req,
        output mask,
        output irq_ready,
        input  irq_valid,
        input  irq_id,
        input  pending
    );

    modport slave (
        input  req,
        input  mask,
        input  irq_ready,
        output irq_valid,
        output irq_id,
        output pending
    );

endinterface

// File: rtl/irq_pend8_pe8_3.sv
// ----------------------------------------------------------------------------
// pe8_3
// Eight-input priority encoder.
//   I[7:0] : request vector, bit 7 highest priority
//   Y[3]   : any bit of I set
//   Y[2:0] : index of the highest set bit (0 when none set)
// ----------------------------------------------------------------------------
module pe8_3 (
    input  logic [7:0] I,
    output logic [3:0] Y
);

    always_comb begin
        Y = 4'b0000;
        // Ascending scan so the highest set index is the last one written.
        for (int i = 0; i < 8; i++) begin
            if (I[i]) begin
                Y = {1'b1, 3'(i)};
            end
        end
    end

endmodule

// File: rtl/irq_pend8.sv
// ----------------------------------------------------------------------------
// irq_pend8
// Eight-input interrupt pending/arbitration stage. Requests are synchronised,
// rising edges (or levels when LEVEL=1) are captured into a pending register,
// the masked pending vector is priority-encoded and the winner is presented
// as a held id with a valid/ready handshake. The accepted bit is cleared on
// the handshake edge.
//   LEVEL : 0 = rising-edge sensitive, sticky pending; 1 = level sensitive
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : irq_pend8_if.slave (req, mask, irq_ready, irq_valid, irq_id,
//           pending)
// ----------------------------------------------------------------------------
module irq_pend8
    import irq_pkg::*;
#(
    parameter bit LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    irq_pend8_if.slave   bus
);

    // State table
    //   state   | meaning
    //   IDLE    | no id presented; re-evaluates the encoder every cycle
    //   PRESENT | irq_id/irq_valid held until irq_ready

    logic [N_IRQ-1:0]    s1_q, s2_q, s3_q;
    logic [N_IRQ-1:0]    pending_q, pending_d;
    logic [N_IRQ-1:0]    rise;
    logic [N_IRQ-1:0]    clr;
    logic [N_IRQ-1:0]    masked;
    logic [3:0]          enc_y;
    logic                hs;
    irq_state_e          state_q, state_d;
    logic [IRQ_ID_W-1:0] irq_id_q, irq_id_d;

    // Two-flop synchroniser plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= bus.req;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign hs   = (state_q == PRESENT) && bus.irq_ready;
    assign clr  = hs ? id_onehot(irq_id_q) : '0;

    // OR-ing rise after the clear lets a new edge win over a same-cycle clear.
    always_comb begin
        pending_d = (pending_q & ~clr) | rise;
        if (LEVEL) begin
            pending_d = s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Mask is applied combinationally; it only reaches the outputs through
    // the FSM registers.
    assign masked = pending_q & bus.mask;

    pe8_3 u_pe8_3 (
        .I (masked),
        .Y (enc_y)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            irq_id_q <= '0;
        end else begin
            state_q  <= state_d;
            irq_id_q <= irq_id_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            IDLE: begin
                if (enc_y[3]) begin
                    state_d  = PRESENT;
                    irq_id_d = enc_y[2:0];
                end
            end
            PRESENT: begin
                if (bus.irq_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM: outputs (valid decoded from the state flop, so the async reset
    // drops it without a clock edge)
    always_comb begin
        bus.irq_valid = (state_q == PRESENT);
        bus.irq_id    = irq_id_q;
        bus.pending   = pending_q;
    end

endmodule

// File: tb/tb_irq_pend8.sv
// ----------------------------------------------------------------------------
// tb_irq_pend8
// Directed bench for irq_pend8: one edge-mode instance and one level-mode
// instance sharing clock and reset, each with its own interface.
// ----------------------------------------------------------------------------
module tb_irq_pend8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    irq_pend8_if bus_e ();
    irq_pend8_if bus_l ();

    irq_pend8 #(.LEVEL(1'b0)) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_e)
    );

    irq_pend8 #(.LEVEL(1'b1)) u_lvl (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus_e.req       = 8'h00;
        bus_e.mask      = 8'hFF;
        bus_e.irq_ready = 1'b0;
        bus_l.req       = 8'h00;
        bus_l.mask      = 8'hFF;
        bus_l.irq_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus_e.req       = 8'hFF;
        bus_e.mask      = 8'hFF;
        bus_e.irq_ready = 1'b0;
        bus_l.req       = 8'hFF;
        bus_l.mask      = 8'hFF;
        bus_l.irq_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus_e.irq_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0b exp=0", bus_e.irq_valid); end
        n_cmp++; if (bus_e.irq_id !== 3'd0) begin n_err++; $display("FAIL rst_id got=%0d exp=0", bus_e.irq_id); end
        n_cmp++; if (bus_e.pending !== 8'h00) begin n_err++; $display("FAIL rst_pending got=%h exp=00", bus_e.pending); end
        n_cmp++; if (bus_l.pending !== 8'h00) begin n_err++; $display("FAIL rst_pending_lvl got=%h exp=00", bus_l.pending); end
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        n_cmp++; if (bus_e.pending !== 8'hFF) begin n_err++; $display("FAIL rst_release_pending got=%h exp=ff", bus_e.pending); end
        n_cmp++; if (bus_l.pending !== 8'hFF) begin n_err++; $display("FAIL rst_release_pending_lvl got=%h exp=ff", bus_l.pending); end
        tick();
        n_cmp++; if (bus_e.irq_valid !== 1'b1 || bus_e.irq_id !== 3'd7) begin n_err++; $display("FAIL rst_first_grant got=%0b/%0d exp=1/7", bus_e.irq_valid, bus_e.irq_id); end
    endtask

    task automatic test_single_edge();
        do_reset();
        bus_e.req = 8'h20;
        tick();
        bus_e.req = 8'h00;
        tick();
        tick();
        n_cmp++; if (bus_e.pending !== 8'h20 || bus_e.irq_valid !== 1'b0) begin n_err++; $display("FAIL single_pending got=%h/%0b exp=20/0", bus_e.pending, bus_e.irq_valid); end
        tick();
        n_cmp++; if (bus_e.irq_valid !== 1'b1 || bus_e.irq_id !== 3'd5) begin n_err++; $display("FAIL single_grant got=%0b/%0d exp=1/5", bus_e.irq_valid, bus_e.irq_id); end
        bus_e.irq_ready = 1'b1;
        tick();
        n_cmp++; if (bus_e.pending !== 8'h00 || bus_e.irq_valid !== 1'b0) begin n_err++; $display("FAIL single_handshake got=%h/%0b exp=00/0", bus_e.pending, bus_e.irq_valid); end
        tick();
        n_cmp++; if (bus_e.irq_valid !== 1'b0) begin n_err++; $display("FAIL single_no_regrant got=%0b exp=0", bus_e.irq_valid); end
        bus_e.irq_ready = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        bus_e.req = 8'h06;
        tick();
        tick();
        tick();
        tick();
        n_cmp++; if (bus_e.irq_valid !== 1'b1 || bus_e.irq_id !== 3'd2) begin n_err++; $display("FAIL prio_first got=%0b/%0d exp=1/2", bus_e.irq_valid, bus_e.irq_id); end
        bus_e.irq_ready = 1'b1;
        tick();
        n_cmp++; if (bus_e.irq_valid !== 1'b0 || bus_e.pending !== 8'h02) begin n_err++; $display("FAIL prio_hs1 got=%0b/%h exp=0/02", bus_e.irq_valid, bus_e.pending); end
        tick();
        n_cmp++; if (bus_e.irq_valid !== 1'b1 || bus_e.irq_id !== 3'd1) begin n_err++; $display("FAIL prio_second got=%0b/%0d exp=1/1", bus_e.irq_valid, bus_e.irq_id); end
        tick();
        n_cmp++; if (bus_e.irq_valid !== 1'b0 || bus_e.pending !== 8'h00) begin n_err++; $display("FAIL prio_hs2 got=%0b/%h exp=0/00", bus_e.irq_valid, bus_e.pending); end
        bus_e.irq_ready = 1'b0;
        bus_e.req       = 8'h00;
    endtask

    task automatic test_stability_mask();
        logic [7:0] mask_seq [5];
        mask_seq[0] = 8'h00;
        mask_seq[1] = 8'h7F;
        mask_seq[2] = 8'hFF;
        mask_seq[3] = 8'h01;
        mask_seq[4] = 8'h80;
        do_reset();
        bus_e.req = 8'h81;
        tick();
        tick();
        tick();
        n_cmp++; if (bus_e.pending !== 8'h81) begin n_err++; $display("FAIL stab_pending got=%h exp=81", bus_e.pending); end
        tick();
        for (int i = 0; i < 5; i++) begin
            bus_e.mask = mask_seq[i];
            tick();
            n_cmp++; if (bus_e.irq_valid !== 1'b1 || bus_e.irq_id !== 3'd7) begin n_err++; $display("FAIL stab_hold[%0d] got=%0b/%0d exp=1/7", i, bus_e.irq_valid, bus_e.irq_id); end
        end
        bus_e.mask      = 8'hFF;
        bus_e.irq_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus_e.irq_valid !== 1'b1 || bus_e.irq_id !== 3'd0) begin n_err++; $display("FAIL stab_next0 got=%0b/%0d exp=1/0", bus_e.irq_valid, bus_e.irq_id); end
        tick();
        bus_e.irq_ready = 1'b0;
        bus_e.req       = 8'h00;
        tick();
        tick();
        tick();
        // Masked-off line stays pending until unmasked.
        bus_e.mask = 8'h7F;
        bus_e.req  = 8'h81;
        tick();
        tick();
        tick();
        tick();
        n_cmp++; if (bus_e.irq_valid !== 1'b1 || bus_e.irq_id !== 3'd0) begin n_err++; $display("FAIL mask_grant0 got=%0b/%0d exp=1/0", bus_e.irq_valid, bus_e.irq_id); end
        bus_e.irq_ready = 1'b1;
        tick();
        tick();
        tick();
        tick();
        n_cmp++; if (bus_e.irq_valid !== 1'b0 || bus_e.pending !== 8'h80) begin n_err++; $display("FAIL mask_held got=%0b/%h exp=0/80", bus_e.irq_valid, bus_e.pending); end
        bus_e.mask = 8'hFF;
        tick();
        n_cmp++; if (bus_e.irq_valid !== 1'b1 || bus_e.irq_id !== 3'd7) begin n_err++; $display("FAIL mask_unmask got=%0b/%0d exp=1/7", bus_e.irq_valid, bus_e.irq_id); end
        tick();
        n_cmp++; if (bus_e.pending !== 8'h00) begin n_err++; $display("FAIL mask_cleared got=%h exp=00", bus_e.pending); end
        bus_e.irq_ready = 1'b0;
        bus_e.req       = 8'h00;
    endtask

    task automatic test_set_wins();
        do_reset();
        bus_e.req = 8'h08;
        tick();
        bus_e.req = 8'h00;
        tick();
        bus_e.req = 8'h08;
        tick();
        bus_e.req = 8'h00;
        n_cmp++; if (bus_e.pending !== 8'h08) begin n_err++; $display("FAIL setwin_pending got=%h exp=08", bus_e.pending); end
        tick();
        n_cmp++; if (bus_e.irq_valid !== 1'b1 || bus_e.irq_id !== 3'd3) begin n_err++; $display("FAIL setwin_grant got=%0b/%0d exp=1/3", bus_e.irq_valid, bus_e.irq_id); end
        bus_e.irq_ready = 1'b1;
        tick();
        n_cmp++; if (bus_e.pending !== 8'h08 || bus_e.irq_valid !== 1'b0) begin n_err++; $display("FAIL setwin_collide got=%h/%0b exp=08/0", bus_e.pending, bus_e.irq_valid); end
        tick();
        n_cmp++; if (bus_e.irq_valid !== 1'b1 || bus_e.irq_id !== 3'd3) begin n_err++; $display("FAIL setwin_regrant got=%0b/%0d exp=1/3", bus_e.irq_valid, bus_e.irq_id); end
        tick();
        n_cmp++; if (bus_e.pending !== 8'h00 || bus_e.irq_valid !== 1'b0) begin n_err++; $display("FAIL setwin_final got=%h/%0b exp=00/0", bus_e.pending, bus_e.irq_valid); end
        bus_e.irq_ready = 1'b0;
    endtask

    task automatic test_level();
        do_reset();
        bus_l.irq_ready = 1'b1;
        bus_l.req       = 8'h10;
        tick();
        tick();
        tick();
        tick();
        n_cmp++; if (bus_l.irq_valid !== 1'b1 || bus_l.irq_id !== 3'd4) begin n_err++; $display("FAIL lvl_grant1 got=%0b/%0d exp=1/4", bus_l.irq_valid, bus_l.irq_id); end
        tick();
        n_cmp++; if (bus_l.irq_valid !== 1'b0 || bus_l.pending !== 8'h10) begin n_err++; $display("FAIL lvl_hs1 got=%0b/%h exp=0/10", bus_l.irq_valid, bus_l.pending); end
        tick();
        n_cmp++; if (bus_l.irq_valid !== 1'b1 || bus_l.irq_id !== 3'd4) begin n_err++; $display("FAIL lvl_grant2 got=%0b/%0d exp=1/4", bus_l.irq_valid, bus_l.irq_id); end
        tick();
        bus_l.req = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        tick();
        n_cmp++; if (bus_l.irq_valid !== 1'b0 || bus_l.pending !== 8'h00) begin n_err++; $display("FAIL lvl_drop got=%0b/%h exp=0/00", bus_l.irq_valid, bus_l.pending); end
        tick();
        n_cmp++; if (bus_l.irq_valid !== 1'b0) begin n_err++; $display("FAIL lvl_quiet got=%0b exp=0", bus_l.irq_valid); end
        bus_l.irq_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus_l.req = 8'h10;
        tick();
        tick();
        tick();
        tick();
        n_cmp++; if (bus_l.irq_valid !== 1'b1 || bus_l.irq_id !== 3'd4) begin n_err++; $display("FAIL arst_pre got=%0b/%0d exp=1/4", bus_l.irq_valid, bus_l.irq_id); end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_l.irq_valid !== 1'b0 || bus_l.irq_id !== 3'd0) begin n_err++; $display("FAIL arst_drop got=%0b/%0d exp=0/0", bus_l.irq_valid, bus_l.irq_id); end
        n_cmp++; if (bus_l.pending !== 8'h00) begin n_err++; $display("FAIL arst_pending got=%h exp=00", bus_l.pending); end
        tick();
        bus_l.req = 8'h00;
        rst_n     = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        test_reset();
        test_single_edge();
        test_priority();
        test_stability_mask();
        test_set_wins();
        test_level();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
